// File: rtl/cpu_clock_ctrl_pkg.sv
// Shared encodings for the CPU clock-enable controller: operating modes and FSM states.
package cpu_clk_pkg;

  typedef enum logic [1:0] {
    MODE_FULL = 2'b00,
    MODE_DIV  = 2'b01,
    MODE_STEP = 2'b10,
    MODE_HALT = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_FULL       = 3'd0,
    ST_DIV        = 3'd1,
    ST_STEP_IDLE  = 3'd2,
    ST_STEP_PULSE = 3'd3,
    ST_HALT       = 3'd4
  } state_e;

  function automatic state_e mode_to_state(input logic [1:0] m);
    state_e st;
    case (mode_e'(m))
      MODE_FULL: st = ST_FULL;
      MODE_DIV:  st = ST_DIV;
      MODE_STEP: st = ST_STEP_IDLE;
      default:   st = ST_HALT;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/cpu_clock_ctrl_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stable-sample debounce and a
// registered one-cycle rising-edge pulse of the debounced level.
module btn_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btnIn,
  output logic level,
  output logic rise
);

  localparam int DB_W = $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] LAST = DB_W'(DB_CYCLES - 1);

  logic [1:0]      sync_q;
  logic [DB_W-1:0] cnt_q;
  logic            level_q;
  logic            level_dly_q;
  logic            rise_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      rise_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], btnIn};
      level_dly_q <= level_q;
      rise_q      <= level_q & ~level_dly_q;
      // Any sample agreeing with the accepted level restarts the stability count.
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == LAST) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + DB_W'(1);
      end
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/cpu_clock_ctrl.sv
// Clock-enable controller: free-running prescaler, mode FSM and registered
// per-channel enable pulses plus a count of channel-0 enables.
module cpu_clock_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int SEL_W     = 5,
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic [NUM_CH*SEL_W-1:0] divSel,
  input  logic                    stepBtn,
  output logic [NUM_CH-1:0]       clkEn,
  output logic [CNT_W-1:0]        cycleCount,
  output logic                    halted
);

  localparam int PRE_W = 2 ** SEL_W;

  logic [PRE_W-1:0]  presc_q;
  state_e            state_q, state_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              halted_q;
  logic              btn_level;
  logic              step_req;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_debounce (
    .clk   (clk),
    .reset (reset),
    .btnIn (stepBtn),
    .level (btn_level),
    .rise  (step_req)
  );

  // Tap s fires when prescaler bits [s:0] are all ones; selects past the top bit clamp.
  function automatic logic tap_hit(input logic [PRE_W-1:0] p, input logic [SEL_W-1:0] s);
    logic [PRE_W-1:0] mask;
    mask = '1;
    if (int'(s) < PRE_W - 1) mask = (PRE_W'(1) << (int'(s) + 1)) - PRE_W'(1);
    return &(p | ~mask);
  endfunction

  always_comb begin
    state_d = mode_to_state(mode);
    if (state_q == ST_STEP_IDLE && step_req && btn_level) state_d = ST_STEP_PULSE;
  end

  always_comb begin
    en_d = '0;
    case (state_q)
      ST_FULL, ST_STEP_PULSE: en_d = '1;
      ST_DIV: begin
        for (int c = 0; c < NUM_CH; c++) begin
          en_d[c] = tap_hit(presc_q, divSel[c*SEL_W +: SEL_W]);
        end
      end
      default: en_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q  <= '0;
      state_q  <= ST_HALT;
      en_q     <= '0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      presc_q  <= presc_q + PRE_W'(1);
      state_q  <= state_d;
      en_q     <= en_d;
      cnt_q    <= cnt_q + CNT_W'(en_d[0]);
      halted_q <= (state_d == ST_HALT);
    end
  end

  assign clkEn      = en_q;
  assign cycleCount = cnt_q;
  assign halted     = halted_q;

endmodule
